// File: rtl/alu_pkg.sv
// Shared ALU constants: widths, lookahead grouping and stage-valid encoding.
package alu_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int GROUP     = 4;
  localparam int NGROUP    = WIDTH_DEF / GROUP;

  localparam logic VLD_EMPTY = 1'b0;
  localparam logic VLD_FULL  = 1'b1;

  function automatic int ngroup(input int w);
    return w / GROUP;
  endfunction

endpackage

// File: rtl/cla_add_pipe_lcu4.sv
// 4-bit lookahead carry unit: bit carries from cin plus group propagate/generate.
module lcu4 (
  input  logic [3:0] p,
  input  logic [3:0] g,
  input  logic       cin,
  output logic [3:0] c,
  output logic       pg,
  output logic       gg
);

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);

  assign pg = &p;
  assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/cla_add_pipe.sv
// Two-stage carry-lookahead add/sub with valid/ready handshake (WIDTH 16..64).
module cla_add_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NG = ngroup(WIDTH);
  localparam int NB = NG / 4;

  logic             s1_valid;
  logic             s1_adv;
  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] p_c;
  logic [WIDTH-1:0] g_c;
  logic [WIDTH-1:0] l1_c;
  logic [NG-1:0]    gp_c;
  logic [NG-1:0]    gg_c;

  logic [WIDTH-1:0] s1_p;
  logic [WIDTH-1:0] s1_g;
  logic             s1_cin;
  logic [NG-1:0]    s1_gp;
  logic [NG-1:0]    s1_gg;

  logic [NG-1:0]    grpc;
  logic [NB-1:0]    bp;
  logic [NB-1:0]    bg;
  logic [NB-1:0]    bc;
  logic [3:0]       tp;
  logic [3:0]       tg;
  logic [3:0]       bc4;
  logic             top_pg;
  logic             top_gg;
  logic [WIDTH-1:0] cb;
  logic [WIDTH-1:0] sum_c;
  logic             cout_c;
  logic             unused_sink;

  assign s1_adv   = (out_valid == VLD_EMPTY) || out_ready;
  assign in_ready = (s1_valid == VLD_EMPTY) || s1_adv;

  assign bx  = b ^ {WIDTH{sub}};
  assign p_c = a ^ bx;
  assign g_c = a & bx;

  for (genvar i = 0; i < NG; i++) begin : g_l1
    lcu4 u_l1 (
      .p   (p_c[GROUP*i +: GROUP]),
      .g   (g_c[GROUP*i +: GROUP]),
      .cin (1'b0),
      .c   (l1_c[GROUP*i +: GROUP]),
      .pg  (gp_c[i]),
      .gg  (gg_c[i])
    );
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_p   <= p_c;
      s1_g   <= g_c;
      s1_cin <= sub;
      s1_gp  <= gp_c;
      s1_gg  <= gg_c;
    end
  end

  for (genvar j = 0; j < NB; j++) begin : g_l2
    lcu4 u_l2 (
      .p   (s1_gp[4*j +: 4]),
      .g   (s1_gg[4*j +: 4]),
      .cin (bc[j]),
      .c   (grpc[4*j +: 4]),
      .pg  (bp[j]),
      .gg  (bg[j])
    );
  end

  // Block P/G padded to four lanes; unused lanes never propagate.
  always_comb begin
    tp = '0;
    tg = '0;
    tp[NB-1:0] = bp;
    tg[NB-1:0] = bg;
  end

  lcu4 u_top (
    .p   (tp),
    .g   (tg),
    .cin (s1_cin),
    .c   (bc4),
    .pg  (top_pg),
    .gg  (top_gg)
  );

  assign bc = bc4[NB-1:0];

  always_comb begin
    cb = '0;
    for (int k = 0; k < NG; k++) begin
      cb[GROUP*k] = grpc[k];
      for (int j = 1; j < GROUP; j++) begin
        cb[GROUP*k+j] = s1_g[GROUP*k+j-1]
                      | (s1_p[GROUP*k+j-1] & cb[GROUP*k+j-1]);
      end
    end
  end

  assign cout_c = s1_gg[NG-1] | (s1_gp[NG-1] & grpc[NG-1]);
  assign sum_c  = s1_p ^ cb;

  assign unused_sink = ^{l1_c, bc4, top_pg, top_gg};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= VLD_EMPTY;
      out_valid <= VLD_EMPTY;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else begin
      if (in_ready)
        s1_valid <= in_valid;
      if (s1_adv)
        out_valid <= s1_valid;
      if (s1_adv && s1_valid) begin
        sum  <= sum_c;
        cout <= cout_c;
        ovf  <= cb[WIDTH-1] ^ cout_c;
        zero <= ~|sum_c;
      end
    end
  end

endmodule

// File: doc/cla_add_pipe.md
CLA_ADD_PIPE -- requirements
Module: cla_add_pipe

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; SHALL be a multiple of 16.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operand beat present.
REQ-005 in_ready  output  1  block accepts a beat this cycle.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 sub  input  1  1 = A-B (B inverted, carry-in 1); 0 = A+B (carry-in 0).
REQ-009 out_valid  output  1  result beat present.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 sum  output  WIDTH  A+B or A-B, modulo 2^WIDTH.
REQ-012 cout  output  1  raw carry out of MSB (for sub: 1 = no borrow).
REQ-013 ovf  output  1  signed overflow.
REQ-014 zero  output  1  sum == 0.

Function
REQ-015 Beat accepted when in_valid && in_ready; beat delivered when out_valid && out_ready.
REQ-016 Stage 1 SHALL register bit p = a^b', g = a&b' (b' = b^{WIDTH{sub}}), carry-in = sub, and per-4-bit-group P/G from first-level lookahead units.
REQ-017 Stage 2 SHALL compute group carries via second-level lookahead over the stage-1 group P/G, form bit carries, and register sum, cout, ovf, zero.
REQ-018 ovf = carry into MSB XOR carry out of MSB; zero computed on the final sum.
REQ-019 Latency: beat accepted at edge k SHALL appear with out_valid=1 after edge k+1.
REQ-020 Throughput one beat per cycle when out_ready is held 1.
REQ-021 s1_adv = !out_valid || out_ready; in_ready = !s1_valid || s1_adv; in_ready SHALL NOT depend on in_valid.
REQ-022 While out_valid && !out_ready, sum/cout/ovf/zero SHALL hold stable and stage 1 SHALL hold its contents.
REQ-023 Simultaneous accept and deliver in the same cycle SHALL neither drop nor duplicate beats.
REQ-024 When stage 1 is empty and output is delivered, out_valid SHALL fall to 0 on the next edge.
REQ-025 Data registers need not change while their valid is 0; outputs other than out_valid are don't-care then.
REQ-026 Result bits SHALL be exact for all operands including wrap-around (0xFFFFFFFF+1 -> 0, cout=1).

Reset
REQ-027 rst=1 at an edge SHALL clear s1_valid and out_valid to 0 and sum, cout, ovf, zero to 0.
REQ-028 Beats in flight at reset SHALL be discarded; in_ready SHALL read 1 in the cycle after reset deasserts.
REQ-029 in_valid during rst SHALL be ignored.

Structure
REQ-030 Shared package/header alu_pkg SHALL hold WIDTH default, GROUP=4, NGROUP=WIDTH/4 and the stage-valid encoding; no local redefinition.
REQ-031 One sub-module is natural: the existing 4-bit lookahead carry unit lcu4, instantiated NGROUP times at level 1 and NGROUP/4 (+1 top for WIDTH=32 two-group chaining) at level 2; no other sub-modules.
REQ-032 No combinational path from a/b/sub to any output; out_ready -> in_ready is the only comb input-to-output path.

Verification
REQ-033 a=0x0000_0005, b=0x0000_0003, sub=0, out_ready=1 -> after 2 edges sum=0x8, cout=0, ovf=0, zero=0.
REQ-034 a=0xFFFF_FFFF, b=0x1, sub=0 -> sum=0, cout=1, ovf=0, zero=1; a=0x7FFF_FFFF, b=0x1 -> sum=0x8000_0000, ovf=1.
REQ-035 a=0x3, b=0x5, sub=1 -> sum=0xFFFF_FFFE, cout=0, ovf=0; a=0x8000_0000, b=0x1, sub=1 -> sum=0x7FFF_FFFF, ovf=1, cout=1.
REQ-036 Back-to-back 3 beats, out_ready=0 for 4 cycles then 1 -> in_ready drops after 2 accepted beats, outputs held stable, all 3 delivered in order, none lost.
REQ-037 Assert rst with 2 beats in flight -> next cycle out_valid=0, sum=0, in_ready=1; no stale beat ever delivered.
REQ-038 10k random beats with random in_valid/out_ready -> every delivered result matches reference a±b, flags, and order.
